apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator that converts a valid/ready command interface into APB transfers.
- Returns each transfer's read data and error status on a valid/ready response interface.
- Sits between a PD0 control agent (sequencer/CPU-side logic) and APB completers such as the AON register file.
- Bounds every transfer with a wait-state timeout so a hung completer cannot stall the agent.

Parameters:
- DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data.
- ADDR_WIDTH, 32, width of PADDR and command address.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  agent consumes response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB completer ready.
- PSLVERR  in  1  APB completer error.

Behaviour:
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- Reset: on a PCLK edge with PRESETn low, state goes to IDLE and every registered output goes to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_*), as does the timeout counter.
- Reset mid-transfer aborts the transfer; no response is produced.
- FSM IDLE: cmd_ready=1. On cmd_valid=1, capture cmd_write/addr/wdata into PWRITE/PADDR/PWDATA and drive PSEL=1, PENABLE=0; go to SETUP.
- FSM SETUP: lasts exactly one cycle. Drive PENABLE=1 and clear the timeout counter; go to ACCESS.
- FSM ACCESS, PREADY=1: complete the transfer.
  - Capture rsp_rdata = PWRITE ? 0 : PRDATA, rsp_err = PSLVERR, rsp_timeout = 0.
  - Set rsp_valid=1, PSEL=0, PENABLE=0; go to RESP.
- FSM ACCESS, PREADY=0: increment the counter.
  - If TIMEOUT_CYCLES != 0 and the counter has reached TIMEOUT_CYCLES-1, abort instead: rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1, PSEL=0, PENABLE=0; go to RESP.
  - So the abort happens after TIMEOUT_CYCLES consecutive PREADY-low ACCESS cycles.
- FSM RESP: hold rsp_* stable while rsp_ready=0. On rsp_ready=1, clear rsp_valid and go to IDLE.
- The next command is accepted no earlier than the cycle after the handshake, so there is no overlap and at most one transfer is in flight.
- APB protocol rules:
  - PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS.
  - After a transfer these signals retain their last values; they change only on command capture.
  - PSEL and PENABLE are never both low during ACCESS.
  - PENABLE is never high outside ACCESS.
- PSLVERR and PRDATA are sampled only in ACCESS when PREADY=1; they are ignored otherwise.
- Latency:
  - Command handshake at edge T gives SETUP in cycle T..T+1 and ACCESS from T+1.
  - Zero-wait completer: rsp_valid is high after edge T+2.
  - Each wait state adds one cycle.
- Simultaneous events:
  - PREADY=1 on the same cycle the counter hits its limit counts as a normal completion, not a timeout.
  - cmd_valid asserted during SETUP/ACCESS/RESP is ignored (cmd_ready=0); the agent must hold it.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit. The counter never wraps; it only runs in ACCESS.

Test Plan:
- Reset/idle: hold PRESETn=0 for 3 cycles, then release. Expect all APB outputs and rsp_* at 0, cmd_ready=1, and PSEL stays 0 with cmd_valid=0.
- Zero-wait write: send cmd write addr 0x0 data 0xA5A5_0001 with PREADY tied 1.
  - Expect PSEL=1/PENABLE=0 for one cycle, then PSEL=1/PENABLE=1 for one cycle, with PADDR/PWDATA stable throughout.
  - Expect rsp_valid=1, rsp_rdata=0, rsp_err=0 two edges after the handshake.
- Read back with wait states: completer holds PREADY low 3 cycles, then PRDATA=0xA5A5_0001 with PREADY=1. Expect 4 ACCESS cycles and rsp_rdata=0xA5A5_0001, rsp_err=0.
- Error and backpressure: read with PSLVERR=1 at completion and rsp_ready held 0 for 5 cycles. Expect rsp_err=1 and rsp_* stable for all 5 cycles, with cmd_ready=0 until the cycle after rsp_ready=1.
- Timeout: TIMEOUT_CYCLES=16 with PREADY stuck 0.
  - Expect the abort after exactly 16 ACCESS cycles: rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL=0.
  - Repeat with PREADY=1 on the 16th cycle: expect normal completion and rsp_timeout=0.
- Reset mid-transfer: assert PRESETn=0 during ACCESS with PREADY low. Expect PSEL/PENABLE=0 after that edge, no rsp_valid, and IDLE after release.

Source files
------------

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
//
// Purpose:
//   Single-outstanding APB initiator. It accepts one command on a valid/ready
//   interface and runs it as an APB SETUP/ACCESS transfer. It then returns the
//   read data and error status on a valid/ready response interface.
//
//   Every ACCESS phase is bounded by a wait-state timeout, so a hung completer
//   cannot stall the agent. Setting TIMEOUT_CYCLES to 0 disables the timeout.
//
// Parameters:
//   DATA_WIDTH     - width of PWDATA/PRDATA and of command/response data
//   ADDR_WIDTH     - width of PADDR and of the command address
//   TIMEOUT_CYCLES - PREADY-low ACCESS cycles before abort (0 = never)
//
// Ports:
//   PCLK, PRESETn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request (registered)
//   PRDATA/PREADY/PSLVERR             APB completion
// -----------------------------------------------------------------------------
module apb_master_bridge #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIM =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;

   // The only combinational output: the bridge takes a command only when idle.
   assign cmd_ready = (state == IDLE);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // PADDR/PWRITE/PWDATA change only here. They keep their last
               // values after a transfer ends.
               if (cmd_valid) begin
                  PWRITE  <= cmd_write;
                  PADDR   <= cmd_addr;
                  PWDATA  <= cmd_wdata;
                  PSEL    <= 1'b1;
                  PENABLE <= 1'b0;
                  state   <= SETUP;
               end
            end

            SETUP: begin
               PENABLE <= 1'b1;
               tmo_cnt <= '0;
               state   <= ACCESS;
            end

            ACCESS: begin
               if (PREADY) begin
                  // A completion on the same cycle the limit is hit wins over
                  // the timeout.
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= RESP;
               end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LIM)) begin
                  // tmo_cnt counts earlier stalled cycles. Hitting LIM here
                  // means this is stalled ACCESS cycle number TIMEOUT_CYCLES.
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_valid   <= 1'b1;
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  state       <= RESP;
               end else if (tmo_cnt != CNT_MAX) begin
                  // Saturate rather than wrap (only reachable when the
                  // timeout is disabled).
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Purpose:
//   Self-checking bench for apb_master_bridge. A behavioural APB completer with
//   its own register array answers transfers. The wait-state count and error
//   response of each transfer are chosen by the main sequence.
//
//   A transaction-level reference model predicts each response. It also
//   predicts the number of ACCESS cycles, from the wait count and the timeout
//   rule.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 16;

   logic          PCLK = 1'b0;
   logic          PRESETn;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err, rsp_timeout;
   logic          PSEL, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic          PREADY, PSLVERR;

   apb_master_bridge #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Completer storage (written via the DUT's APB pins) and reference storage
   // (written from the commands by the model).
   logic [DW-1:0] comp_mem [16];
   logic [DW-1:0] ref_mem  [16];

   int cur_waits = 0;
   bit cur_err   = 1'b0;
   int acc_n     = 0;

   // Completer: PREADY goes high on ACCESS cycle cur_waits+1. Outside a
   // completing cycle, PREADY/PRDATA/PSLVERR carry noise.
   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         acc_n = acc_n + 1;
         if (acc_n > cur_waits) begin
            PREADY  = 1'b1;
            PRDATA  = comp_mem[PADDR[5:2]];
            PSLVERR = cur_err;
            if (PWRITE && !cur_err) comp_mem[PADDR[5:2]] = PWDATA;
         end else begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end
      end else begin
         acc_n   = 0;
         PREADY  = 1'($urandom);
         PRDATA  = $urandom;
         PSLVERR = 1'($urandom);
      end
   end

   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int waits, input bit err, input int bp);
      int            guard;
      int            acc;
      int            idx;
      bit            tmo;
      int            exp_acc;
      logic [DW-1:0] exp_rd;
      bit            exp_err;
      idx     = int'(addr[5:2]);
      tmo     = (TO != 0) && (waits >= TO);
      exp_acc = tmo ? TO : waits + 1;
      exp_rd  = (wr || tmo) ? '0 : ref_mem[idx];
      exp_err = tmo ? 1'b1 : err;
      if (wr && !err && !tmo) ref_mem[idx] = wdata;
      cur_waits = waits;
      cur_err   = err;

      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge PCLK);
         guard++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_wait", cmd_ready, 1);
         cmd_valid = 1'b0;
         return;
      end

      @(negedge PCLK);
      // Scramble the command bus: the bridge must not recapture it.
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_paddr", PADDR, addr);
      chk("setup_pwrite", PWRITE, wr);
      chk("setup_pwdata", PWDATA, wdata);
      chk("busy_cmd_ready", cmd_ready, 0);

      acc = 0;
      guard = 0;
      @(negedge PCLK);
      while (PSEL && PENABLE && guard < 200) begin
         acc++;
         chk("access_paddr", PADDR, addr);
         chk("access_pwdata", PWDATA, wdata);
         chk("access_rsp_valid", rsp_valid, 0);
         @(negedge PCLK);
         guard++;
      end
      chk("access_cycles", acc, exp_acc);
      chk("done_psel", PSEL, 0);
      chk("done_penable", PENABLE, 0);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", rsp_err, exp_err);
      chk("rsp_timeout", rsp_timeout, tmo);
      chk("retain_paddr", PADDR, addr);

      for (int i = 0; i < bp; i++) begin
         @(negedge PCLK);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, exp_rd);
         chk("bp_rsp_err", rsp_err, exp_err);
         chk("bp_rsp_timeout", rsp_timeout, tmo);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_psel", PSEL, 0);
      end
      rsp_ready = 1'b1;
      chk("hs_cmd_ready", cmd_ready, 0);
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", rsp_valid, 0);
      chk("post_cmd_ready", cmd_ready, 1);
   endtask

   initial begin
      PRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         comp_mem[i] = 32'h0101_0101 * i;
         ref_mem[i]  = 32'h0101_0101 * i;
      end

      // Reset and idle
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk("rst_psel", PSEL, 0);
      chk("rst_penable", PENABLE, 0);
      chk("rst_pwrite", PWRITE, 0);
      chk("rst_paddr", PADDR, 0);
      chk("rst_pwdata", PWDATA, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      PRESETn = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         chk("idle_psel", PSEL, 0);
         chk("idle_cmd_ready", cmd_ready, 1);
      end

      // Directed scenarios
      run_txn(1'b1, 32'h0, 32'hA5A5_0001, 0, 1'b0, 0);   // zero-wait write
      run_txn(1'b0, 32'h0, 32'h0, 3, 1'b0, 0);           // read back, 3 waits
      run_txn(1'b0, 32'h0, 32'h0, 0, 1'b1, 5);           // error + backpressure
      run_txn(1'b0, 32'h10, 32'h0, 1000, 1'b0, 0);       // stuck completer
      run_txn(1'b1, 32'h14, 32'hDEAD_BEEF, 1000, 1'b0, 1); // stuck write: no store
      run_txn(1'b0, 32'h10, 32'h0, TO - 1, 1'b0, 2);     // ready on last cycle
      run_txn(1'b0, 32'h14, 32'h0, 0, 1'b0, 0);          // aborted write left data

      // Reset during ACCESS with PREADY low
      cur_waits = 1000;
      cur_err   = 1'b0;
      @(negedge PCLK);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h20;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      repeat (4) @(negedge PCLK);
      chk("mid_in_access", PENABLE, 1);
      PRESETn = 1'b0;
      @(negedge PCLK);
      chk("mid_psel", PSEL, 0);
      chk("mid_penable", PENABLE, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      PRESETn = 1'b1;
      repeat (3) begin
         @(negedge PCLK);
         chk("mid_post_cmd_ready", cmd_ready, 1);
         chk("mid_post_rsp_valid", rsp_valid, 0);
         chk("mid_post_psel", PSEL, 0);
      end

      // Randomized traffic
      for (int t = 0; t < 40; t++) begin
         bit            wr;
         logic [AW-1:0] a;
         int            w;
         wr = 1'($urandom);
         a  = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
         w  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 3)
                                          : $urandom_range(0, 4);
         run_txn(wr, a, $urandom, w, ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
